semaforo_monitor: RTL and testbench

- Passive protocol checker on the light-output side of the semaforo controller.
- Samples the A and B light buses every cycle and checks encoding, mutual exclusion, A/B transition order and A phase durations.
- Reports the first violation (sticky), pulses on every violation, and keeps violation and completed-A-cycle counters.
- Instantiated beside semaforo in benches and in the debug build; it never drives the lights.

---
 rtl/semaforo_monitor.sv | 129 ++++++++++++
 tb/tb_semaforo_monitor.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/semaforo_monitor.sv
// Passive checker on the semaforo A/B light outputs: flags encoding, conflict,
// transition-order and A phase-duration violations, with sticky first code and counters.
module semaforo_monitor #(
  parameter logic [7:0] T_VERDE    = 8'd3,
  parameter logic [7:0] T_AMARELO  = 8'd3,
  parameter logic [7:0] T_VERMELHO = 8'd3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] A,
  input  logic [2:0] B,
  output logic       err,
  output logic [2:0] err_code,
  output logic       err_pulse,
  output logic [7:0] viol_count,
  output logic [7:0] ciclos_a
);
  // state  | meaning
  // S_SYNC | first sample after reset; must be A verde with B vermelho
  // S_RUN  | every sample checked against previous lights and A duration
  typedef enum logic {S_SYNC, S_RUN} state_t;

  localparam logic [2:0] VERDE    = 3'b001;
  localparam logic [2:0] AMARELO  = 3'b010;
  localparam logic [2:0] VERMELHO = 3'b100;

  // Over-duration limits are 9 bits so T=255 never fires against the saturated counter.
  localparam logic [8:0] LIM_V = {1'b0, T_VERDE}    + 9'd1;
  localparam logic [8:0] LIM_A = {1'b0, T_AMARELO}  + 9'd1;
  localparam logic [8:0] LIM_R = {1'b0, T_VERMELHO} + 9'd1;

  state_t     r_state;
  logic [2:0] r_prev_a, r_prev_b;
  logic [7:0] r_dur;
  logic       r_err, r_pulse;
  logic [2:0] r_code;
  logic [7:0] r_viol, r_ciclos;

  logic       w_a_ok, w_b_ok, w_a_chg, w_b_chg, w_a_step_ok;
  logic [7:0] w_dur_inc;
  logic [8:0] w_dur_ext;
  logic [7:1] w_hit;
  logic [2:0] w_code;

  function automatic logic legal_step(input logic [2:0] p, input logic [2:0] c);
    return (p == VERDE && c == AMARELO) || (p == AMARELO && c == VERMELHO) ||
           (p == VERMELHO && c == VERDE);
  endfunction

  assign w_a_ok      = (A == VERDE) || (A == AMARELO) || (A == VERMELHO);
  assign w_b_ok      = (B == VERDE) || (B == AMARELO) || (B == VERMELHO);
  assign w_a_chg     = (A != r_prev_a);
  assign w_b_chg     = (B != r_prev_b);
  assign w_a_step_ok = legal_step(r_prev_a, A);
  assign w_dur_inc   = (r_dur == 8'hFF) ? r_dur : r_dur + 8'd1;
  assign w_dur_ext   = {1'b0, w_dur_inc};

  always_comb begin
    w_hit  = '0;
    w_code = 3'd0;
    if (r_state == S_SYNC) begin
      w_hit[3] = !(A == VERDE && B == VERMELHO);
    end else begin
      w_hit[1] = !w_a_ok || !w_b_ok;
      w_hit[2] = (A != VERMELHO) && (B != VERMELHO);
      if (w_a_ok) begin
        if (w_a_chg) begin
          w_hit[3] = !w_a_step_ok;
          w_hit[4] = (r_prev_a == AMARELO) && (r_dur != T_AMARELO);
        end else begin
          w_hit[4] = (A == AMARELO)  && (w_dur_ext == LIM_A);
          w_hit[5] = (A == VERDE)    && (w_dur_ext == LIM_V);
          w_hit[6] = (A == VERMELHO) && (w_dur_ext == LIM_R);
        end
      end
      if (w_b_ok && w_b_chg)
        w_hit[7] = !legal_step(r_prev_b, B) || (r_prev_b == VERMELHO && A != VERMELHO);
    end
    for (int k = 7; k >= 1; k--)
      if (w_hit[k]) w_code = 3'(k);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_SYNC;
      r_prev_a <= 3'd0;
      r_prev_b <= 3'd0;
      r_dur    <= 8'd0;
      r_err    <= 1'b0;
      r_code   <= 3'd0;
      r_pulse  <= 1'b0;
      r_viol   <= 8'd0;
      r_ciclos <= 8'd0;
    end else begin
      r_pulse <= |w_hit;
      if (|w_hit) begin
        if (r_viol != 8'hFF) r_viol <= r_viol + 8'd1;
        if (!r_err) begin
          r_err  <= 1'b1;
          r_code <= w_code;
        end
      end
      case (r_state)
        S_SYNC: begin
          r_prev_a <= A;
          r_prev_b <= B;
          r_dur    <= 8'd1;
          r_state  <= S_RUN;
        end
        default: begin
          // Illegally encoded lights are not history; keep the last legal value.
          if (w_a_ok) begin
            r_prev_a <= A;
            r_dur    <= w_a_chg ? 8'd1 : w_dur_inc;
            if (w_a_chg && w_a_step_ok && r_prev_a == VERMELHO)
              r_ciclos <= r_ciclos + 8'd1;
          end
          if (w_b_ok) r_prev_b <= B;
        end
      endcase
    end
  end

  assign err        = r_err;
  assign err_code   = r_code;
  assign err_pulse  = r_pulse;
  assign viol_count = r_viol;
  assign ciclos_a   = r_ciclos;
endmodule

// File: tb/tb_semaforo_monitor.sv
// Bench for semaforo_monitor: directed scenarios against fixed expectations and
// randomized light traffic against a rule-level reference model.
module tb_semaforo_monitor;
  localparam int TV = 3, TA = 3, TR = 3;

  logic       clk, rst;
  logic [2:0] a_in, b_in;
  logic       err, err_pulse;
  logic [2:0] err_code;
  logic [7:0] viol_count, ciclos_a;

  int errors = 0;
  int checks = 0;

  semaforo_monitor #(.T_VERDE(8'd3), .T_AMARELO(8'd3), .T_VERMELHO(8'd3)) dut (
    .clk(clk), .rst(rst), .A(a_in), .B(b_in),
    .err(err), .err_code(err_code), .err_pulse(err_pulse),
    .viol_count(viol_count), .ciclos_a(ciclos_a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: lights as colour indices 0=verde 1=amarelo 2=vermelho, -1 illegal.
  int m_synced, m_dur, m_err, m_code, m_pulse, m_viol, m_ciclos;
  logic [2:0] m_prev_a, m_prev_b;

  function automatic int color(input logic [2:0] v);
    case (v)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_synced = 0; m_dur = 0; m_err = 0; m_code = 0; m_pulse = 0;
    m_viol = 0; m_ciclos = 0; m_prev_a = 3'd0; m_prev_b = 3'd0;
  endtask

  task automatic model_step(input logic [2:0] a, input logic [2:0] b);
    bit [7:0] hits;
    int ca, cb, pa, pb, lowest;
    hits = '0;
    if (m_synced == 0) begin
      if (!(a == 3'b001 && b == 3'b100)) hits[3] = 1'b1;
      m_prev_a = a; m_prev_b = b; m_dur = 1; m_synced = 1;
    end else begin
      ca = color(a); cb = color(b); pa = color(m_prev_a); pb = color(m_prev_b);
      if (ca < 0 || cb < 0) hits[1] = 1'b1;
      if (ca != 2 && cb != 2) hits[2] = 1'b1;
      if (ca >= 0) begin
        if (a != m_prev_a) begin
          if (pa < 0 || ca != (pa + 1) % 3) hits[3] = 1'b1;
          else if (pa == 2) m_ciclos = (m_ciclos + 1) % 256;
          if (pa == 1 && m_dur != TA) hits[4] = 1'b1;
          m_dur = 1;
        end else begin
          if (m_dur < 255) m_dur++;
          if (ca == 0 && m_dur == TV + 1) hits[5] = 1'b1;
          if (ca == 1 && m_dur == TA + 1) hits[4] = 1'b1;
          if (ca == 2 && m_dur == TR + 1) hits[6] = 1'b1;
        end
        m_prev_a = a;
      end
      if (cb >= 0) begin
        if (b != m_prev_b) begin
          if (pb < 0 || cb != (pb + 1) % 3) hits[7] = 1'b1;
          if (pb == 2 && ca != 2) hits[7] = 1'b1;
        end
        m_prev_b = b;
      end
    end
    lowest = 0;
    for (int k = 7; k >= 1; k--) if (hits[k]) lowest = k;
    m_pulse = (lowest != 0);
    if (m_pulse) begin
      if (m_viol < 255) m_viol++;
      if (m_err == 0) begin m_err = 1; m_code = lowest; end
    end
  endtask

  task automatic drive(input logic [2:0] a, input logic [2:0] b);
    a_in = a; b_in = b;
    @(posedge clk); #1;
    if (rst) model_reset(); else model_step(a, b);
  endtask

  task automatic apply_reset();
    rst = 1'b1; drive(3'b001, 3'b100); rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; drive(3'b111, 3'b000); drive(3'b001, 3'b100); rst = 1'b0;
    checks++;
    if ({err, err_code, err_pulse, viol_count, ciclos_a} !== 21'd0) begin
      errors++;
      $display("FAIL reset_state: got err=%0b code=%0d pulse=%0b viol=%0d ciclos=%0d, want all 0",
               err, err_code, err_pulse, viol_count, ciclos_a);
    end
  endtask

  task automatic test_nominal();
    int pulses = 0;
    apply_reset();
    for (int r = 0; r < 2; r++) begin
      repeat (3) begin drive(3'b001, 3'b100); pulses += err_pulse; end
      repeat (3) begin drive(3'b010, 3'b100); pulses += err_pulse; end
      drive(3'b100, 3'b001); pulses += err_pulse;
      drive(3'b100, 3'b001); pulses += err_pulse;
      drive(3'b100, 3'b010); pulses += err_pulse;
    end
    drive(3'b001, 3'b100); pulses += err_pulse;
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL nominal_pulses: got %0d, want 0", pulses); end
    checks++;
    if (err !== 1'b0 || viol_count !== 8'd0) begin
      errors++; $display("FAIL nominal_err: got err=%0b viol=%0d, want 0/0", err, viol_count);
    end
    checks++;
    if (ciclos_a !== 8'd2) begin errors++; $display("FAIL nominal_ciclos: got %0d, want 2", ciclos_a); end
  endtask

  task automatic test_green_bounds();
    apply_reset();
    drive(3'b001, 3'b100);
    repeat (3) drive(3'b010, 3'b100);
    repeat (3) drive(3'b100, 3'b100);
    drive(3'b001, 3'b100);
    checks++;
    if (err !== 1'b0 || ciclos_a !== 8'd1) begin
      errors++; $display("FAIL green_short: got err=%0b ciclos=%0d, want 0/1", err, ciclos_a);
    end
    drive(3'b001, 3'b100); drive(3'b001, 3'b100);
    checks++;
    if (err_pulse !== 1'b0) begin errors++; $display("FAIL green_at_limit: got pulse=%0b, want 0", err_pulse); end
    drive(3'b001, 3'b100);
    checks++;
    if (err_pulse !== 1'b1 || err_code !== 3'd5 || viol_count !== 8'd1) begin
      errors++;
      $display("FAIL green_long: got pulse=%0b code=%0d viol=%0d, want 1/5/1", err_pulse, err_code, viol_count);
    end
    drive(3'b001, 3'b100);
    checks++;
    if (err_pulse !== 1'b0 || viol_count !== 8'd1) begin
      errors++; $display("FAIL green_once: got pulse=%0b viol=%0d, want 0/1", err_pulse, viol_count);
    end
  endtask

  task automatic test_yellow_short();
    apply_reset();
    repeat (3) drive(3'b001, 3'b100);
    repeat (2) drive(3'b010, 3'b100);
    drive(3'b100, 3'b100);
    checks++;
    if (err_code !== 3'd4 || viol_count !== 8'd1 || err_pulse !== 1'b1) begin
      errors++;
      $display("FAIL yellow_short: got code=%0d viol=%0d pulse=%0b, want 4/1/1", err_code, viol_count, err_pulse);
    end
  endtask

  task automatic test_encoding();
    apply_reset();
    drive(3'b001, 3'b100);
    drive(3'b011, 3'b100);
    checks++;
    if (err_code !== 3'd1 || viol_count !== 8'd1) begin
      errors++; $display("FAIL enc_bad_a: got code=%0d viol=%0d, want 1/1", err_code, viol_count);
    end
    drive(3'b001, 3'b001);
    checks++;
    if (err_code !== 3'd1 || viol_count !== 8'd2 || err_pulse !== 1'b1) begin
      errors++;
      $display("FAIL enc_sticky: got code=%0d viol=%0d pulse=%0b, want 1/2/1", err_code, viol_count, err_pulse);
    end
  endtask

  task automatic test_order();
    apply_reset();
    drive(3'b001, 3'b100);
    drive(3'b100, 3'b100);
    checks++;
    if (err_code !== 3'd3 || viol_count !== 8'd1) begin
      errors++; $display("FAIL order_a: got code=%0d viol=%0d, want 3/1", err_code, viol_count);
    end
    apply_reset();
    drive(3'b001, 3'b100);
    drive(3'b100, 3'b011);
    checks++;
    if (err_code !== 3'd1 || viol_count !== 8'd1) begin
      errors++; $display("FAIL order_multi: got code=%0d viol=%0d, want 1/1", err_code, viol_count);
    end
  endtask

  task automatic test_reset_midrun();
    drive(3'b100, 3'b100);
    rst = 1'b1; drive(3'b100, 3'b100); rst = 1'b0;
    checks++;
    if ({err, err_code, err_pulse, viol_count, ciclos_a} !== 21'd0) begin
      errors++;
      $display("FAIL midrun_reset: got err=%0b code=%0d pulse=%0b viol=%0d ciclos=%0d, want all 0",
               err, err_code, err_pulse, viol_count, ciclos_a);
    end
    drive(3'b100, 3'b100);
    checks++;
    if (err_code !== 3'd3) begin errors++; $display("FAIL sync_bad: got code=%0d, want 3", err_code); end
    apply_reset();
    drive(3'b001, 3'b100);
    checks++;
    if (err !== 1'b0 || err_pulse !== 1'b0) begin
      errors++; $display("FAIL sync_good: got err=%0b pulse=%0b, want 0/0", err, err_pulse);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    drive(3'b001, 3'b100);
    repeat (300) drive(3'b000, 3'b000);
    checks++;
    if (viol_count !== 8'd255 || err_code !== 3'd1) begin
      errors++; $display("FAIL viol_saturate: got viol=%0d code=%0d, want 255/1", viol_count, err_code);
    end
  endtask

  task automatic test_ciclos_wrap();
    apply_reset();
    drive(3'b001, 3'b100);
    for (int i = 0; i < 256; i++) begin
      repeat (3) drive(3'b010, 3'b100);
      drive(3'b100, 3'b100);
      drive(3'b001, 3'b100);
      if (i == 254) begin
        checks++;
        if (ciclos_a !== 8'd255) begin errors++; $display("FAIL ciclos_255: got %0d, want 255", ciclos_a); end
      end
    end
    checks++;
    if (ciclos_a !== 8'd0 || err !== 1'b0) begin
      errors++; $display("FAIL ciclos_wrap: got ciclos=%0d err=%0b, want 0/0", ciclos_a, err);
    end
  endtask

  task automatic test_random();
    logic [2:0] qa[$], qb[$];
    logic [2:0] a, b;
    int gv, ya, rv, bmode;
    apply_reset();
    for (int it = 0; it < 120; it++) begin
      gv = $urandom_range(1, 4); ya = $urandom_range(2, 4); rv = $urandom_range(2, 4);
      bmode = $urandom_range(0, 1);
      repeat (gv) begin qa.push_back(3'b001); qb.push_back(3'b100); end
      repeat (ya) begin qa.push_back(3'b010); qb.push_back(3'b100); end
      for (int k = 0; k < rv; k++) begin
        qa.push_back(3'b100);
        if (rv >= 3 && bmode == 1) qb.push_back((k == rv - 1) ? 3'b010 : 3'b001);
        else qb.push_back(3'b100);
      end
    end
    while (qa.size() > 0) begin
      a = qa.pop_front(); b = qb.pop_front();
      if ($urandom_range(0, 19) == 0) a = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) b = 3'($urandom_range(0, 7));
      rst = ($urandom_range(0, 149) == 0);
      drive(a, b);
      rst = 1'b0;
      checks++;
      if (err !== 1'(m_err) || err_code !== 3'(m_code)) begin
        errors++;
        $display("FAIL rand_err: A=%b B=%b got err=%0b code=%0d, want %0d/%0d", a, b, err, err_code, m_err, m_code);
      end
      checks++;
      if (err_pulse !== 1'(m_pulse) || viol_count !== 8'(m_viol)) begin
        errors++;
        $display("FAIL rand_pulse: A=%b B=%b got pulse=%0b viol=%0d, want %0d/%0d", a, b, err_pulse, viol_count, m_pulse, m_viol);
      end
      checks++;
      if (ciclos_a !== 8'(m_ciclos)) begin
        errors++; $display("FAIL rand_ciclos: got %0d, want %0d", ciclos_a, m_ciclos);
      end
    end
  endtask

  initial begin
    rst = 1'b1; a_in = 3'b001; b_in = 3'b100;
    model_reset();
    test_reset();
    test_nominal();
    test_green_bounds();
    test_yellow_short();
    test_encoding();
    test_order();
    test_reset_midrun();
    test_saturation();
    test_ciclos_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
